pip_cla_n: RTL

Parametrised, fully pipelined carry-lookahead adder/subtractor: WIDTH-bit operands split into BLOCK-bit lookahead groups, one pipeline stage per group carry, with valid/ready flow control and global stall. It generalises the fixed 16-bit pipelined CLA and is the arithmetic datapath element for wider streaming units. It accepts one operation per cycle, and results emerge in issue order after a fixed latency.

---
 rtl/pip_cla_n.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pip_cla_n.sv
// Pipelined carry-lookahead adder/subtractor: one stage per BLOCK-bit group carry, valid/ready flow, global stall.
// Optional signed-overflow output enabled by defining PIP_CLA_OVF_EN.
module pip_cla_n #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef PIP_CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NB = WIDTH / BLOCK;

    generate
        if ((WIDTH % BLOCK) != 0 || BLOCK < 2 || BLOCK > 8) begin : g_bad_param
            $error("pip_cla_n: WIDTH must be a multiple of BLOCK and BLOCK must be 2..8");
        end
    endgenerate

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Stage 0 holds the operand P/G; stage j (1..NB) has group carries 0..j-1 resolved.
    logic [WIDTH-1:0] p_q [0:NB];
    logic [WIDTH-1:0] g_q [0:NB-1];
    logic [WIDTH:0]   c_q [0:NB];
    logic [NB:0]      v_q;
    logic [WIDTH:0]   c_nxt [1:NB];

    assign in_ready = !(out_valid && !out_ready);
    assign advance  = in_ready;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    // Two-level lookahead across one group: every carry is a sum of products of
    // the group's G/P terms and the incoming group carry, no ripple inside the group.
    function automatic logic [WIDTH:0] group_carry(
        input logic [WIDTH:0]   c,
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] g,
        input int               k
    );
        logic [WIDTH:0] r;
        logic           acc;
        logic           pr;
        r = c;
        for (int i = 0; i < BLOCK; i++) begin
            acc = 1'b0;
            pr  = 1'b1;
            for (int m = i; m >= 0; m--) begin
                acc = acc | (pr & g[k*BLOCK+m]);
                pr  = pr & p[k*BLOCK+m];
            end
            acc = acc | (pr & c[k*BLOCK]);
            r[k*BLOCK+i+1] = acc;
        end
        return r;
    endfunction

    always_comb begin
        for (int j = 1; j <= NB; j++) begin
            c_nxt[j] = group_carry(c_q[j-1], p_q[j-1], g_q[j-1], j - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q       <= '0;
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
`ifdef PIP_CLA_OVF_EN
            ovf       <= 1'b0;
`endif
            for (int j = 0; j <= NB; j++) begin
                p_q[j] <= '0;
                c_q[j] <= '0;
            end
            for (int j = 0; j < NB; j++) begin
                g_q[j] <= '0;
            end
        end else if (advance) begin
            v_q[0] <= in_valid;
            p_q[0] <= a ^ b_eff;
            g_q[0] <= a & b_eff;
            c_q[0] <= {{WIDTH{1'b0}}, c0};
            for (int j = 1; j <= NB; j++) begin
                v_q[j] <= v_q[j-1];
                p_q[j] <= p_q[j-1];
                c_q[j] <= c_nxt[j];
            end
            for (int j = 1; j < NB; j++) begin
                g_q[j] <= g_q[j-1];
            end
            out_valid <= v_q[NB];
            if (v_q[NB]) begin
                s    <= p_q[NB] ^ c_q[NB][WIDTH-1:0];
                cout <= c_q[NB][WIDTH];
`ifdef PIP_CLA_OVF_EN
                ovf  <= c_q[NB][WIDTH] ^ c_q[NB][WIDTH-1];
`endif
            end
        end
    end

endmodule
